// File: rtl/mips_status_pkg.sv
// Shared status, result and run-state encodings for the MIPS core, the run monitor and benches.
package mips_status_pkg;

    localparam int STATUS_W = 2;
    localparam int RESULT_W = 2;

    typedef enum logic [STATUS_W-1:0] {
        STATUS_R_OK     = 2'd0,
        STATUS_I_OK     = 2'd1,
        STATUS_OVERFLOW = 2'd2,
        STATUS_END      = 2'd3
    } status_e;

    typedef enum logic [RESULT_W-1:0] {
        RESULT_NONE     = 2'd0,
        RESULT_END      = 2'd1,
        RESULT_OVERFLOW = 2'd2,
        RESULT_TIMEOUT  = 2'd3
    } result_e;

    typedef enum logic {
        STATE_RUN  = 1'b0,
        STATE_HALT = 1'b1
    } run_state_e;

    function automatic logic is_terminal(input logic [STATUS_W-1:0] status);
        return (status == STATUS_END) || (status == STATUS_OVERFLOW);
    endfunction

    // Only meaningful for terminal statuses; anything else maps to NONE.
    function automatic result_e status_to_result(input logic [STATUS_W-1:0] status);
        case (status)
            STATUS_END:      return RESULT_END;
            STATUS_OVERFLOW: return RESULT_OVERFLOW;
            default:         return RESULT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/status_log_fifo.sv
// Single-clock first-word-fall-through register FIFO holding timestamped status events.
module status_log_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Storage is not reset, so the head reads as zero while nothing is held.
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mips_run_monitor.sv
// Observes the core status stream: cycle budget, per-status counters, event log and done/result.
module mips_run_monitor
    import mips_status_pkg::*;
#(
    parameter int MAX_CYCLE = 120000,
    parameter int CYCLE_W   = 17,
    parameter int LOG_DEPTH = 16,
    localparam int LCNT_W   = $clog2(LOG_DEPTH) + 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [STATUS_W-1:0] i_status,
    input  logic                i_status_valid,
    input  logic                i_pop,
    output logic                o_log_valid,
    output logic [STATUS_W-1:0] o_log_status,
    output logic [CYCLE_W-1:0]  o_log_cycle,
    output logic [LCNT_W-1:0]   o_log_count,
    output logic                o_log_dropped,
    output logic [CYCLE_W-1:0]  o_inst_count,
    output logic [CYCLE_W-1:0]  o_ovf_count,
    output logic [CYCLE_W-1:0]  o_cycle,
    output logic                o_done,
    output logic [RESULT_W-1:0] o_result
);

    localparam int ENTRY_W = STATUS_W + CYCLE_W;

    run_state_e          state;
    run_state_e          state_next;
    result_e             result;
    result_e             result_next;
    logic [CYCLE_W-1:0]  cycle;
    logic [CYCLE_W-1:0]  inst_count;
    logic [CYCLE_W-1:0]  ovf_count;
    logic                log_dropped;
    logic                accept;
    logic                at_limit;
    logic                log_full;
    logic                log_empty;
    logic                log_drop;
    logic [ENTRY_W-1:0]  log_head;

    assign accept   = (state == STATE_RUN) && i_status_valid;
    assign at_limit = (cycle == CYCLE_W'(MAX_CYCLE - 1));

    // A terminal status on the last budgeted cycle takes priority over the timeout.
    always_comb begin
        state_next  = state;
        result_next = result;
        if (state == STATE_RUN) begin
            if (accept && is_terminal(i_status)) begin
                state_next  = STATE_HALT;
                result_next = status_to_result(i_status);
            end else if (at_limit) begin
                state_next  = STATE_HALT;
                result_next = RESULT_TIMEOUT;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= STATE_RUN;
            result <= RESULT_NONE;
        end else begin
            state  <= state_next;
            result <= result_next;
        end
    end

    // The cycle counter stops on the halting edge so it reports the final cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cycle       <= '0;
            inst_count  <= '0;
            ovf_count   <= '0;
            log_dropped <= 1'b0;
        end else begin
            if ((state == STATE_RUN) && (state_next == STATE_RUN)) begin
                cycle <= cycle + 1'b1;
            end
            if (accept) begin
                inst_count <= inst_count + 1'b1;
            end
            if (accept && (i_status == STATUS_OVERFLOW)) begin
                ovf_count <= ovf_count + 1'b1;
            end
            if (log_drop) begin
                log_dropped <= 1'b1;
            end
        end
    end

    assign log_drop = accept && log_full && !(i_pop && !log_empty);

    status_log_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .push    (accept),
        .wr_data ({i_status, cycle}),
        .pop     (i_pop),
        .rd_data (log_head),
        .full    (log_full),
        .empty   (log_empty),
        .count   (o_log_count)
    );

    assign o_log_valid   = !log_empty;
    assign o_log_status  = log_head[CYCLE_W +: STATUS_W];
    assign o_log_cycle   = log_head[CYCLE_W-1:0];
    assign o_log_dropped = log_dropped;
    assign o_inst_count  = inst_count;
    assign o_ovf_count   = ovf_count;
    assign o_cycle       = cycle;
    assign o_done        = (state == STATE_HALT);
    assign o_result      = result;

endmodule

// File: tb/tb_mips_run_monitor.sv
// Randomized and directed bench for mips_run_monitor against a queue-based reference model.
module tb_mips_run_monitor;
    import mips_status_pkg::*;

    localparam int MAX_CYCLE = 50;
    localparam int CYCLE_W   = 8;
    localparam int LOG_DEPTH = 4;
    localparam int LCNT_W    = $clog2(LOG_DEPTH) + 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [1:0]         status = 2'd0;
    logic               status_valid = 1'b0;
    logic               pop = 1'b0;
    logic               log_valid;
    logic [1:0]         log_status;
    logic [CYCLE_W-1:0] log_cycle;
    logic [LCNT_W-1:0]  log_count;
    logic               log_dropped;
    logic [CYCLE_W-1:0] inst_count;
    logic [CYCLE_W-1:0] ovf_count;
    logic [CYCLE_W-1:0] cycle;
    logic               done;
    logic [1:0]         result;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: a queue of logged events plus plain integer counters.
    int m_q_status[$];
    int m_q_cycle[$];
    int m_cycle;
    int m_inst;
    int m_ovf;
    int m_result;
    bit m_halt;
    bit m_dropped;

    mips_run_monitor #(
        .MAX_CYCLE (MAX_CYCLE),
        .CYCLE_W   (CYCLE_W),
        .LOG_DEPTH (LOG_DEPTH)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_status       (status),
        .i_status_valid (status_valid),
        .i_pop          (pop),
        .o_log_valid    (log_valid),
        .o_log_status   (log_status),
        .o_log_cycle    (log_cycle),
        .o_log_count    (log_count),
        .o_log_dropped  (log_dropped),
        .o_inst_count   (inst_count),
        .o_ovf_count    (ovf_count),
        .o_cycle        (cycle),
        .o_done         (done),
        .o_result       (result)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic checkAll(input string where);
        checkOutput({where, ":cycle"}, 32'(cycle), m_cycle);
        checkOutput({where, ":inst"}, 32'(inst_count), m_inst % 256);
        checkOutput({where, ":ovf"}, 32'(ovf_count), m_ovf % 256);
        checkOutput({where, ":done"}, 32'(done), 32'(m_halt));
        checkOutput({where, ":result"}, 32'(result), m_result);
        checkOutput({where, ":log_count"}, 32'(log_count), m_q_status.size());
        checkOutput({where, ":log_valid"}, 32'(log_valid), 32'(m_q_status.size() > 0));
        checkOutput({where, ":dropped"}, 32'(log_dropped), 32'(m_dropped));
        if (m_q_status.size() > 0) begin
            checkOutput({where, ":head_status"}, 32'(log_status), m_q_status[0]);
            checkOutput({where, ":head_cycle"}, 32'(log_cycle), m_q_cycle[0]);
        end
    endtask

    task automatic modelReset();
        m_q_status.delete();
        m_q_cycle.delete();
        m_cycle = 0;
        m_inst = 0;
        m_ovf = 0;
        m_result = 0;
        m_halt = 1'b0;
        m_dropped = 1'b0;
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, releases on a falling edge.
    task automatic resetDut();
        status_valid = 1'b0;
        pop = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst:cycle", 32'(cycle), 0);
        checkOutput("rst:inst", 32'(inst_count), 0);
        checkOutput("rst:ovf", 32'(ovf_count), 0);
        checkOutput("rst:done", 32'(done), 0);
        checkOutput("rst:result", 32'(result), 0);
        checkOutput("rst:log_count", 32'(log_count), 0);
        checkOutput("rst:log_valid", 32'(log_valid), 0);
        checkOutput("rst:dropped", 32'(log_dropped), 0);
        checkOutput("rst:head_status", 32'(log_status), 0);
        checkOutput("rst:head_cycle", 32'(log_cycle), 0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs (caller is at a falling edge), update the model, check.
    task automatic applyStimulus(input bit valid, input logic [1:0] st, input bit p);
        bit pop_ok;
        bit push;
        bit was_full;
        status_valid = valid;
        status = st;
        pop = p;
        @(posedge clk);
        pop_ok = p && (m_q_status.size() > 0);
        push = !m_halt && valid;
        was_full = (m_q_status.size() == LOG_DEPTH);
        if (pop_ok) begin
            void'(m_q_status.pop_front());
            void'(m_q_cycle.pop_front());
        end
        if (push) begin
            if (was_full && !pop_ok) begin
                m_dropped = 1'b1;
            end else begin
                m_q_status.push_back(int'(st));
                m_q_cycle.push_back(m_cycle);
            end
            m_inst++;
            if (st == 2'd2) m_ovf++;
        end
        if (!m_halt) begin
            if (push && (st == 2'd2 || st == 2'd3)) begin
                m_halt = 1'b1;
                m_result = (st == 2'd3) ? 1 : 2;
            end else if (m_cycle == MAX_CYCLE - 1) begin
                m_halt = 1'b1;
                m_result = 3;
            end else begin
                m_cycle++;
            end
        end
        #1 checkAll("step");
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exp_s[4];
        int exp_c[4];
        exp_s = '{0, 1, 0, 3};
        exp_c = '{2, 3, 5, 8};
        modelReset();

        // Normal run ending in END@8, then a status after halt that must be ignored.
        resetDut();
        for (int c = 0; c <= 11; c++) begin
            case (c)
                2:       applyStimulus(1'b1, STATUS_R_OK, 1'b0);
                3:       applyStimulus(1'b1, STATUS_I_OK, 1'b0);
                5:       applyStimulus(1'b1, STATUS_R_OK, 1'b0);
                8:       applyStimulus(1'b1, STATUS_END, 1'b0);
                10:      applyStimulus(1'b1, STATUS_I_OK, 1'b0);
                default: applyStimulus(1'b0, STATUS_R_OK, 1'b0);
            endcase
        end
        checkOutput("normal:inst", 32'(inst_count), 4);
        checkOutput("normal:done", 32'(done), 1);
        checkOutput("normal:result", 32'(result), 1);
        checkOutput("normal:cycle", 32'(cycle), 8);
        for (int i = 0; i < 4; i++) begin
            checkOutput("normal:log_status", 32'(log_status), exp_s[i]);
            checkOutput("normal:log_cycle", 32'(log_cycle), exp_c[i]);
            applyStimulus(1'b0, STATUS_R_OK, 1'b1);
        end

        // Overflow terminates the run.
        resetDut();
        for (int c = 0; c <= 6; c++) begin
            case (c)
                1:       applyStimulus(1'b1, STATUS_I_OK, 1'b0);
                4:       applyStimulus(1'b1, STATUS_OVERFLOW, 1'b0);
                default: applyStimulus(1'b0, STATUS_R_OK, 1'b0);
            endcase
        end
        checkOutput("ovf:result", 32'(result), 2);
        checkOutput("ovf:ovf_count", 32'(ovf_count), 1);
        checkOutput("ovf:inst", 32'(inst_count), 2);
        checkOutput("ovf:log_count", 32'(log_count), 2);

        // Timeout with non-terminal traffic and a popping consumer.
        resetDut();
        for (int c = 0; c < MAX_CYCLE + 4; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        checkOutput("timeout:done", 32'(done), 1);
        checkOutput("timeout:result", 32'(result), 3);
        checkOutput("timeout:cycle", 32'(cycle), MAX_CYCLE - 1);

        // END on the last budgeted cycle wins over the timeout.
        resetDut();
        for (int c = 0; c < MAX_CYCLE + 2; c++) begin
            applyStimulus(c == MAX_CYCLE - 1, STATUS_END, 1'b0);
        end
        checkOutput("late_end:result", 32'(result), 1);
        checkOutput("late_end:inst", 32'(inst_count), 1);

        // Log capacity, push+pop while full, pop on empty.
        resetDut();
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, 2'(c % 2), 1'b0);
        end
        checkOutput("cap:log_count", 32'(log_count), 4);
        checkOutput("cap:dropped", 32'(log_dropped), 1);
        checkOutput("cap:inst", 32'(inst_count), 6);
        checkOutput("cap:head_cycle", 32'(log_cycle), 0);
        applyStimulus(1'b1, STATUS_I_OK, 1'b1);
        checkOutput("cap:pushpop_count", 32'(log_count), 4);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, STATUS_R_OK, 1'b1);
        end
        checkOutput("cap:empty_count", 32'(log_count), 0);

        // Reset in the middle of a run clears everything; a new run then ends normally.
        resetDut();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, STATUS_I_OK, 1'b0);
        end
        resetDut();
        applyStimulus(1'b0, STATUS_R_OK, 1'b0);
        applyStimulus(1'b1, STATUS_END, 1'b0);
        checkOutput("midreset:result", 32'(result), 1);
        checkOutput("midreset:log_cycle", 32'(log_cycle), 1);

        // Randomized runs with rare terminal statuses and traffic after halt.
        for (int r = 0; r < 10; r++) begin
            int n;
            resetDut();
            n = $urandom_range(20, 70);
            for (int c = 0; c < n; c++) begin
                int pick;
                logic [1:0] st;
                pick = $urandom_range(0, 15);
                st = (pick == 0) ? STATUS_END : (pick == 1) ? STATUS_OVERFLOW : 2'(pick % 2);
                applyStimulus(1'($urandom_range(0, 1)), st, $urandom_range(0, 3) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
